// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [2:0] LEN_BYTE = 3'd1;
  localparam logic [2:0] LEN_HALF = 3'd2;
  localparam logic [2:0] LEN_WORD = 3'd4;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_READ,
    MEM_WRITE
  } mem_state_t;

  function automatic logic [7:0] byte_sel(input logic [DATA_WIDTH-1:0] w, input logic [2:0] i);
    logic [DATA_WIDTH-1:0] s;
    s = w >> {i, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serves instruction fetches and LSB loads/stores over the byte-wide RAM/IO bus,
// one byte per cycle, assembling little-endian words and pulsing ready when done.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IO_BIT = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_rollback,
  input  logic                  in_inst_ena,
  input  logic [ADDR_W-1:0]     in_inst_addr,
  output logic                  out_inst_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  input  logic                  in_data_ena,
  input  logic                  in_data_wr,
  input  logic [2:0]            in_data_len,
  input  logic [ADDR_W-1:0]     in_data_addr,
  input  logic [DATA_WIDTH-1:0] in_data_wdata,
  output logic                  out_data_ready,
  output logic [DATA_WIDTH-1:0] out_data_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  mem_state_t state, state_nxt;
  logic [2:0]            cnt, len;
  logic [ADDR_W-1:0]     base, cur_a, pend_addr;
  logic [DATA_WIDTH-1:0] wdata, asm_q, asm_nxt;
  logic                  cur_inst, pend;
  logic                  wr_stall, rd_done, wr_last, start_data, start_inst;

  assign cur_a      = base + ADDR_W'(cnt);
  assign wr_stall   = (cur_a[IO_BIT -: 2] == 2'b11) && io_buffer_full;
  assign rd_done    = (state == MEM_READ) && (cnt == len) && !in_rollback;
  assign wr_last    = (state == MEM_WRITE) && !wr_stall && (cnt == len - 3'd1);
  // Rollback drops a same-cycle load but a store is already committed.
  assign start_data = (state == MEM_IDLE) && in_data_ena && (in_data_wr || !in_rollback);
  assign start_inst = (state == MEM_IDLE) && !start_data && !in_rollback && (pend || in_inst_ena);

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MEM_IDLE: begin
        if (start_data)      state_nxt = in_data_wr ? MEM_WRITE : MEM_READ;
        else if (start_inst) state_nxt = MEM_READ;
      end
      MEM_READ:  if (in_rollback || cnt == len) state_nxt = MEM_IDLE;
      MEM_WRITE: if (wr_last) state_nxt = MEM_IDLE;
      default:   state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    mem_a    = '0;
    mem_wr   = 1'b0;
    mem_dout = '0;
    case (state)
      MEM_READ: if (cnt < len) mem_a = cur_a;
      MEM_WRITE: begin
        mem_a    = cur_a;
        mem_wr   = !wr_stall;
        mem_dout = byte_sel(wdata, cnt);
      end
      default: ;
    endcase
  end

  // The byte arriving in the final sampling cycle is merged directly into the ready value.
  always_comb begin
    asm_nxt = asm_q;
    case (cnt)
      3'd1:    asm_nxt[7:0]   = mem_din;
      3'd2:    asm_nxt[15:8]  = mem_din;
      3'd3:    asm_nxt[23:16] = mem_din;
      3'd4:    asm_nxt[31:24] = mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      len            <= '0;
      base           <= '0;
      wdata          <= ZERO_DATA;
      cur_inst       <= 1'b0;
      asm_q          <= ZERO_DATA;
      out_inst_ready <= 1'b0;
      out_data_ready <= 1'b0;
      out_inst       <= ZERO_DATA;
      out_data_rdata <= ZERO_DATA;
    end else begin
      out_inst_ready <= 1'b0;
      out_data_ready <= 1'b0;
      case (state)
        MEM_IDLE: begin
          cnt   <= '0;
          asm_q <= ZERO_DATA;
          if (start_data) begin
            base     <= in_data_addr;
            len      <= in_data_len;
            wdata    <= in_data_wdata;
            cur_inst <= 1'b0;
          end else if (start_inst) begin
            base     <= pend ? pend_addr : in_inst_addr;
            len      <= LEN_WORD;
            cur_inst <= 1'b1;
          end
        end
        MEM_READ: begin
          cnt   <= cnt + 3'd1;
          asm_q <= asm_nxt;
          if (rd_done) begin
            if (cur_inst) begin
              out_inst_ready <= 1'b1;
              out_inst       <= asm_nxt;
            end else begin
              out_data_ready <= 1'b1;
              out_data_rdata <= asm_nxt;
            end
          end
        end
        MEM_WRITE: begin
          if (!wr_stall) cnt <= cnt + 3'd1;
          if (wr_last) out_data_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || in_rollback) begin
      pend      <= 1'b0;
      pend_addr <= rst ? '0 : pend_addr;
    end else if (in_inst_ena && !(start_inst && !pend)) begin
      pend      <= 1'b1;
      pend_addr <= in_inst_addr;
    end else if (start_inst) begin
      pend      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-bus memory model, directed timing scenarios and
// randomized transactions checked against a word-level reference memory.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_rollback = 1'b0;
  logic        in_inst_ena = 1'b0;
  logic [31:0] in_inst_addr = '0;
  logic        out_inst_ready;
  logic [31:0] out_inst;
  logic        in_data_ena = 1'b0;
  logic        in_data_wr = 1'b0;
  logic [2:0]  in_data_len = 3'd1;
  logic [31:0] in_data_addr = '0;
  logic [31:0] in_data_wdata = '0;
  logic        out_data_ready;
  logic [31:0] out_data_rdata;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [7:0] ram     [int unsigned];
  logic [7:0] ref_mem [int unsigned];
  logic [31:0] cap_a;
  logic        cap_wr;
  logic [7:0]  cap_d;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32), .IO_BIT(17)) dut (
    .clk(clk), .rst(rst), .in_rollback(in_rollback),
    .in_inst_ena(in_inst_ena), .in_inst_addr(in_inst_addr),
    .out_inst_ready(out_inst_ready), .out_inst(out_inst),
    .in_data_ena(in_data_ena), .in_data_wr(in_data_wr), .in_data_len(in_data_len),
    .in_data_addr(in_data_addr), .in_data_wdata(in_data_wdata),
    .out_data_ready(out_data_ready), .out_data_rdata(out_data_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;
      32'h1001: return 8'h05;
      32'h1002: return 8'h00;
      32'h1003: return 8'h00;
      32'h0040: return 8'hFF;
      default:  return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
    endcase
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int unsigned n);
    logic [31:0] v;
    v = '0;
    for (int unsigned i = 0; i < n; i++) v |= 32'(ref_rd(a + 32'(i))) << (8 * i);
    return v;
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == 2'b11;
  endfunction

  // Byte-wide RAM: address/write captured mid-cycle, read byte presented the next cycle.
  always @(negedge clk) begin
    cap_a  = mem_a;
    cap_wr = mem_wr;
    cap_d  = mem_dout;
  end

  always @(posedge clk) begin
    #1;
    mem_din = bus_rd(cap_a);
    if (cap_wr === 1'b1) ram[cap_a] = cap_d;
  end

  task automatic cyc_begin;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc_begin;
    cyc_begin;
    #2;
    checks++;
    if ({mem_a, mem_wr, mem_dout, out_inst_ready, out_data_ready, out_inst, out_data_rdata} !== '0)
      $display("FAIL reset_outputs: mem_a=%h wr=%b dout=%h ir=%b dr=%b inst=%h rdata=%h, expected all 0",
               mem_a, mem_wr, mem_dout, out_inst_ready, out_data_ready, out_inst, out_data_rdata);
    if ({mem_a, mem_wr, mem_dout, out_inst_ready, out_data_ready, out_inst, out_data_rdata} !== '0) errors++;
    cyc_begin;
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    logic [31:0] exp_a;
    cyc_begin;
    in_inst_ena = 1'b1; in_inst_addr = 32'h1000;
    for (int c = 1; c <= 8; c++) begin
      cyc_begin;
      in_inst_ena = 1'b0;
      #2;
      exp_a = (c <= 4) ? 32'h1000 + 32'(c - 1) : 32'h0;
      checks++;
      if (mem_a !== exp_a || mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL fetch_bus c=%0d: mem_a=%h wr=%b, expected %h 0", c, mem_a, mem_wr, exp_a);
      end
      checks++;
      if (out_inst_ready !== (c == 6)) begin
        errors++;
        $display("FAIL fetch_ready c=%0d: got %b expected %b", c, out_inst_ready, c == 6);
      end
      if (c == 6) begin
        checks++;
        if (out_inst !== 32'h0000_0513) begin
          errors++;
          $display("FAIL fetch_word: got %h expected 00000513", out_inst);
        end
      end
    end
  endtask

  task automatic test_arbitration;
    logic [31:0] exp_a;
    cyc_begin;
    in_inst_ena = 1'b1; in_inst_addr = 32'h20;
    in_data_ena = 1'b1; in_data_wr = 1'b0; in_data_len = 3'd1; in_data_addr = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      cyc_begin;
      in_inst_ena = 1'b0; in_data_ena = 1'b0;
      #2;
      exp_a = (c == 1) ? 32'h40 : (c >= 4 && c <= 7) ? 32'h20 + 32'(c - 4) : 32'h0;
      checks++;
      if (mem_a !== exp_a) begin
        errors++;
        $display("FAIL arb_addr c=%0d: mem_a=%h expected %h", c, mem_a, exp_a);
      end
      checks++;
      if (out_data_ready !== (c == 3) || out_inst_ready !== (c == 9)) begin
        errors++;
        $display("FAIL arb_ready c=%0d: data=%b inst=%b expected %b %b", c, out_data_ready, out_inst_ready, c == 3, c == 9);
      end
      if (c == 3 || c == 9) begin
        checks++;
        if (out_data_rdata !== 32'h0000_00FF) begin
          errors++;
          $display("FAIL arb_rdata c=%0d: got %h expected 000000ff", c, out_data_rdata);
        end
      end
      if (c == 9) begin
        checks++;
        if (out_inst !== ref_word(32'h20, 4)) begin
          errors++;
          $display("FAIL arb_inst: got %h expected %h", out_inst, ref_word(32'h20, 4));
        end
      end
    end
  endtask

  task automatic test_store;
    cyc_begin;
    in_data_ena = 1'b1; in_data_wr = 1'b1; in_data_len = 3'd2;
    in_data_addr = 32'h100; in_data_wdata = 32'h1234_ABCD;
    ref_mem[32'h100] = 8'hCD;
    ref_mem[32'h101] = 8'hAB;
    for (int c = 1; c <= 5; c++) begin
      cyc_begin;
      in_data_ena = 1'b0;
      #2;
      checks++;
      if (mem_wr !== (c <= 2) || out_data_ready !== (c == 3)) begin
        errors++;
        $display("FAIL store_ctl c=%0d: wr=%b ready=%b expected %b %b", c, mem_wr, out_data_ready, c <= 2, c == 3);
      end
      if (c <= 2) begin
        checks++;
        if (mem_a !== 32'h100 + 32'(c - 1) || mem_dout !== ((c == 1) ? 8'hCD : 8'hAB)) begin
          errors++;
          $display("FAIL store_byte c=%0d: a=%h d=%h", c, mem_a, mem_dout);
        end
      end
    end
  endtask

  task automatic test_io_stall;
    cyc_begin;
    in_data_ena = 1'b1; in_data_wr = 1'b1; in_data_len = 3'd1;
    in_data_addr = 32'h3_0000; in_data_wdata = 32'h5A5A_5A77;
    ref_mem[32'h3_0000] = 8'h77;
    for (int c = 1; c <= 6; c++) begin
      cyc_begin;
      in_data_ena = 1'b0;
      io_buffer_full = (c <= 3);
      #2;
      checks++;
      if (mem_wr !== (c == 4) || out_data_ready !== (c == 5)) begin
        errors++;
        $display("FAIL io_stall c=%0d: wr=%b ready=%b expected %b %b", c, mem_wr, out_data_ready, c == 4, c == 5);
      end
      if (c <= 4) begin
        checks++;
        if (mem_a !== 32'h3_0000 || mem_dout !== 8'h77) begin
          errors++;
          $display("FAIL io_hold c=%0d: a=%h d=%h expected 00030000 77", c, mem_a, mem_dout);
        end
      end
    end
    io_buffer_full = 1'b0;
  endtask

  task automatic test_rollback;
    for (int rb = 1; rb <= 5; rb++) begin
      cyc_begin;
      in_inst_ena = 1'b1; in_inst_addr = 32'h200 + 32'(16 * rb);
      for (int c = 1; c <= rb + 8; c++) begin
        cyc_begin;
        in_rollback = (c == rb);
        in_inst_ena = (c == rb + 1);
        in_inst_addr = 32'h300;
        #2;
        if (c == rb + 1) begin
          checks++;
          if (mem_a !== 32'h0) begin
            errors++;
            $display("FAIL rollback_idle rb=%0d: mem_a=%h expected 0", rb, mem_a);
          end
        end
        checks++;
        if (out_inst_ready !== (c == rb + 7)) begin
          errors++;
          $display("FAIL rollback_ready rb=%0d c=%0d: got %b expected %b", rb, c, out_inst_ready, c == rb + 7);
        end
        if (c == rb + 7) begin
          checks++;
          if (out_inst !== ref_word(32'h300, 4)) begin
            errors++;
            $display("FAIL rollback_refetch rb=%0d: got %h expected %h", rb, out_inst, ref_word(32'h300, 4));
          end
        end
      end
      in_rollback = 1'b0; in_inst_ena = 1'b0;
    end
  endtask

  task automatic test_rollback_pending;
    cyc_begin;
    in_data_ena = 1'b1; in_data_wr = 1'b1; in_data_len = 3'd4;
    in_data_addr = 32'h600; in_data_wdata = 32'hDEAD_BEEF;
    for (int unsigned i = 0; i < 4; i++) ref_mem[32'h600 + i] = 8'(32'hDEAD_BEEF >> (8 * i));
    ref_mem[32'h800] = 8'h42;
    for (int c = 1; c <= 14; c++) begin
      cyc_begin;
      in_inst_ena = (c == 1); in_inst_addr = 32'h700;
      in_rollback = (c == 2 || c == 5 || c == 7);
      in_data_ena = (c == 5 || c == 7);
      in_data_wr = (c == 7); in_data_len = 3'd1;
      in_data_addr = (c == 7) ? 32'h800 : 32'h40;
      in_data_wdata = 32'h0000_0042;
      #2;
      checks++;
      if (out_data_ready !== (c == 5 || c == 9) || out_inst_ready !== 1'b0 || mem_wr !== (c <= 4 || c == 8)) begin
        errors++;
        $display("FAIL rollback_pending c=%0d: dr=%b ir=%b wr=%b expected %b 0 %b",
                 c, out_data_ready, out_inst_ready, mem_wr, c == 5 || c == 9, c <= 4 || c == 8);
      end
    end
    in_rollback = 1'b0; in_data_ena = 1'b0; in_inst_ena = 1'b0;
  endtask

  task automatic test_random;
    for (int t = 0; t < 80; t++) begin
      int unsigned kind, n, exp_lat, lat, idx;
      logic [31:0] a, wd, exp_val, got;
      logic [24:0] full;
      logic spurious;
      kind = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0:       n = 1;
        1:       n = 2;
        default: n = 4;
      endcase
      if (kind == 0) n = 4;
      case ($urandom_range(0, 5))
        0:       a = 32'hFFFF_FFFF - $urandom_range(0, 3);
        1:       a = 32'h3_0000 + $urandom_range(0, 255);
        default: a = 32'h2000 + $urandom_range(0, 255);
      endcase
      wd = $urandom;
      full = 25'($urandom) & 25'($urandom) & 25'h000_01FE;
      exp_val = '0;
      exp_lat = 0;
      got = '0;
      if (kind == 2) begin
        idx = 0;
        for (int c = 1; c <= 20 && exp_lat == 0; c++)
          if (!(is_io(a + 32'(idx)) && full[c])) begin
            idx++;
            if (idx == n) exp_lat = c + 1;
          end
        for (int unsigned i = 0; i < n; i++) ref_mem[a + i] = 8'(wd >> (8 * i));
      end else begin
        exp_lat = n + 2;
        exp_val = ref_word(a, n);
      end
      cyc_begin;
      if (kind == 0) begin
        in_inst_ena = 1'b1; in_inst_addr = a;
      end else begin
        in_data_ena = 1'b1; in_data_wr = (kind == 2); in_data_len = 3'(n);
        in_data_addr = a; in_data_wdata = wd;
      end
      lat = 0;
      spurious = 1'b0;
      for (int c = 1; c <= 24 && lat == 0; c++) begin
        cyc_begin;
        in_inst_ena = 1'b0; in_data_ena = 1'b0;
        io_buffer_full = (kind == 2) && full[c];
        #2;
        if ((kind == 0) ? out_data_ready : out_inst_ready) spurious = 1'b1;
        if ((kind == 0) ? out_inst_ready : out_data_ready) begin
          lat = c;
          got = (kind == 0) ? out_inst : out_data_rdata;
        end
      end
      io_buffer_full = 1'b0;
      checks++;
      if (lat !== exp_lat || spurious) begin
        errors++;
        $display("FAIL random_latency t=%0d kind=%0d a=%h n=%0d: lat=%0d (0=timeout) spurious=%b expected %0d",
                 t, kind, a, n, lat, spurious, exp_lat);
      end
      if (kind != 2) begin
        checks++;
        if (got !== exp_val) begin
          errors++;
          $display("FAIL random_data t=%0d kind=%0d a=%h n=%0d: got %h expected %h", t, kind, a, n, got, exp_val);
        end
      end
      cyc_begin;
      #2;
      checks++;
      if (out_inst_ready !== 1'b0 || out_data_ready !== 1'b0) begin
        errors++;
        $display("FAIL random_pulse t=%0d: ir=%b dr=%b expected 0 0", t, out_inst_ready, out_data_ready);
      end
    end
  endtask

  task automatic test_reset_midstore;
    cyc_begin;
    in_data_ena = 1'b1; in_data_wr = 1'b1; in_data_len = 3'd4;
    in_data_addr = 32'h500; in_data_wdata = 32'h8765_4321;
    ref_mem[32'h500] = 8'h21;
    ref_mem[32'h501] = 8'h43;
    for (int c = 1; c <= 10; c++) begin
      cyc_begin;
      in_data_ena = 1'b0;
      in_inst_ena = (c == 1); in_inst_addr = 32'h900;
      rst = (c == 2);
      #2;
      if (c == 3) begin
        checks++;
        if ({mem_a, mem_wr, mem_dout, out_inst_ready, out_data_ready, out_inst, out_data_rdata} !== '0) begin
          errors++;
          $display("FAIL midstore_reset: a=%h wr=%b d=%h ir=%b dr=%b inst=%h rdata=%h expected all 0",
                   mem_a, mem_wr, mem_dout, out_inst_ready, out_data_ready, out_inst, out_data_rdata);
        end
      end
      if (c >= 4) begin
        checks++;
        if (mem_a !== 32'h0 || mem_wr !== 1'b0 || out_inst_ready !== 1'b0 || out_data_ready !== 1'b0) begin
          errors++;
          $display("FAIL midstore_quiet c=%0d: a=%h wr=%b ir=%b dr=%b expected idle", c, mem_a, mem_wr, out_inst_ready, out_data_ready);
        end
      end
    end
    rst = 1'b0; in_inst_ena = 1'b0;
  endtask

  task automatic test_memory_image;
    foreach (ref_mem[k]) begin
      checks++;
      if (bus_rd(k) !== ref_mem[k]) begin
        errors++;
        $display("FAIL memory_image @%h: got %h expected %h", k, bus_rd(k), ref_mem[k]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_fetch;
    test_arbitration;
    test_store;
    test_io_stall;
    test_rollback;
    test_rollback_pending;
    test_random;
    test_reset_midstore;
    test_memory_image;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
